// File: rtl/decrypt_unit_pkg.sv
// Shared configuration for the encrypt/decrypt datapaths: the bit permutation,
// its inverse, the rotate helper and the configuration record.
package encrypt_config;

  localparam int DW    = 8;
  localparam int NKEYS = 3;

  // Forward permutation: output bit i takes input bit PERM_MAP[3*i +: 3].
  // Listed from bit 7 down to bit 0.
  localparam logic [23:0] PERM_MAP = {3'd4, 3'd2, 3'd7, 3'd1, 3'd5, 3'd0, 3'd6, 3'd3};

  typedef struct packed {
    logic [DW-1:0] k1;
    logic [DW-1:0] k2;
    logic [DW-1:0] k3;
    logic [2:0]    rot_freq;
    logic          shift_en;
    logic [2:0]    shift_amt;
    logic          mode;
  } cfg_t;

  // Inverse permutation built from the same table: scatter bit i back to its source.
  function automatic logic [DW-1:0] inv_perm(input logic [DW-1:0] y);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) r[PERM_MAP[3*i +: 3]] = y[i];
    return r;
  endfunction

  // Bit rotation to the right; amt = 0 returns x unchanged.
  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input logic [2:0] amt);
    logic [2*DW-1:0] t;
    t = {x, x} >> amt;
    return t[DW-1:0];
  endfunction

endpackage

// File: rtl/decrypt_unit_key_sched.sv
// Key schedule: holds the configuration shadow, the key-ring index and the
// byte counter, and presents the key/config that the current byte must use.
import encrypt_config::*;

module decrypt_key_sched (
  input  logic          clk,
  input  logic          rst,
  input  cfg_t          cfg_i,
  input  logic          cfg_ld,
  input  logic          sync,
  input  logic          en,
  output logic [DW-1:0] key_o,
  output logic          mode_o,
  output logic          shift_en_o,
  output logic [2:0]    shift_amt_o
);

  cfg_t       cfg_q;
  cfg_t       cfg_eff;
  logic [1:0] kidx_q, kidx_d, kidx_cur;
  logic [2:0] cnt_q, cnt_d, cnt_cur;
  logic       restart;

  // Effective config/key for this cycle, and the schedule step for the accepted byte.
  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cfg_eff  = cfg_ld ? cfg_i : cfg_q;
    restart  = cfg_ld | sync;
    kidx_cur = restart ? 2'd0 : kidx_q;
    cnt_cur  = restart ? 3'd0 : cnt_q;
    kidx_d   = kidx_cur;
    cnt_d    = cnt_cur;
    unique case (kidx_cur)
      2'd0:    key_o = cfg_eff.k3;
      2'd1:    key_o = cfg_eff.k1;
      default: key_o = cfg_eff.k2;
    endcase
    if (en && cfg_eff.rot_freq != 3'd0) begin
      if (cnt_cur == cfg_eff.rot_freq - 3'd1) begin
        cnt_d  = 3'd0;
        kidx_d = (kidx_cur == 2'(NKEYS - 1)) ? 2'd0 : kidx_cur + 2'd1;
      end else begin
        cnt_d = cnt_cur + 3'd1;
      end
    end
    mode_o      = cfg_eff.mode;
    shift_en_o  = cfg_eff.shift_en;
    shift_amt_o = cfg_eff.shift_amt;
  end

  // Shadow config, key index and byte counter.
  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q  <= '0;
      kidx_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      if (cfg_ld) cfg_q <= cfg_i;
      kidx_q <= kidx_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/decrypt_unit.sv
// Receive-side decryptor: two-stage pipeline, XOR key -> inverse permutation
// -> optional rotate-right, or straight bypass. One byte per cycle, latency 2.
import encrypt_config::*;

module decrypt_unit (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          en,
  input  logic [DW-1:0] k1,
  input  logic [DW-1:0] k2,
  input  logic [DW-1:0] k3,
  input  logic [2:0]    rot_freq,
  input  logic          shift_en,
  input  logic [2:0]    shift_amt,
  input  logic          mode,
  input  logic          cfg_ld,
  input  logic          sync,
  output logic [DW-1:0] dout,
  output logic          v
);

  cfg_t          cfg_in;
  logic [DW-1:0] key_cur;
  logic          mode_cur, shen_cur;
  logic [2:0]    amt_cur;

  logic [DW-1:0] d_q, key_q, dout_q, dout_d;
  logic          mode_q, shen_q, v1_q, v_q;
  logic [2:0]    amt_q;

  assign cfg_in = '{k1: k1, k2: k2, k3: k3, rot_freq: rot_freq, shift_en: shift_en,
                    shift_amt: shift_amt, mode: mode};

  decrypt_key_sched u_key_sched (
    .clk         (clk),
    .rst         (rst),
    .cfg_i       (cfg_in),
    .cfg_ld      (cfg_ld),
    .sync        (sync),
    .en          (en),
    .key_o       (key_cur),
    .mode_o      (mode_cur),
    .shift_en_o  (shen_cur),
    .shift_amt_o (amt_cur)
  );

  // Stage 1: capture the byte together with the config it must be decoded with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q    <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      shen_q <= 1'b0;
      amt_q  <= 3'd0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= en;
      if (en) begin
        d_q    <= din;
        key_q  <= key_cur;
        mode_q <= mode_cur;
        shen_q <= shen_cur;
        amt_q  <= amt_cur;
      end
    end
  end

  // Stage 2 next value: decode a valid byte, otherwise hold the last output.
  always_comb begin
    dout_d = dout_q;
    if (v1_q) begin
      dout_d = mode_q ? rotr(inv_perm(d_q ^ key_q), shen_q ? amt_q : 3'd0) : d_q;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      v_q    <= 1'b0;
    end else begin
      dout_q <= dout_d;
      v_q    <= v1_q;
    end
  end

  assign dout = dout_q;
  assign v    = v_q;

endmodule

// File: tb/tb_decrypt_unit.sv
// Self-checking bench: a behavioural encryptor builds the cipher stream, and a
// reference model predicts v/dout from the key-ring rules by byte count.
module tb_decrypt_unit;
  import encrypt_config::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       en = 1'b0;
  logic [7:0] k1 = '0, k2 = '0, k3 = '0;
  logic [2:0] rot_freq = '0;
  logic       shift_en = 1'b0;
  logic [2:0] shift_amt = '0;
  logic       mode = 1'b0;
  logic       cfg_ld = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] dout;
  logic       v;

  decrypt_unit dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .k1(k1), .k2(k2), .k3(k3),
    .rot_freq(rot_freq), .shift_en(shift_en), .shift_amt(shift_amt), .mode(mode),
    .cfg_ld(cfg_ld), .sync(sync), .dout(dout), .v(v)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pin config, shadow config, bytes since last restart, output pipeline.
  cfg_t       pin_cfg;
  cfg_t       shadow;
  int         n_byte;
  bit         s1v, s2v;
  logic [7:0] s1d, s2d;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_perm(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[PERM_MAP[3*i +: 3]];
    return r;
  endfunction

  function automatic logic [7:0] ref_rotl(input logic [7:0] x, input int a);
    logic [15:0] t;
    t = {x, x} << a;
    return t[15:8];
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.k1        = 8'($urandom);
    c.k2        = 8'($urandom);
    c.k3        = 8'($urandom);
    c.rot_freq  = 3'($urandom);
    c.shift_en  = 1'($urandom);
    c.shift_amt = 3'($urandom);
    c.mode      = ($urandom_range(3) != 0);
    return c;
  endfunction

  task automatic model_clear();
    shadow = '0;
    n_byte = 0;
    s1v = 0; s2v = 0;
    s1d = '0; s2d = '0;
  endtask

  // One clock: in decrypt mode pt is plaintext and is encrypted here; in bypass it is sent raw.
  task automatic step(input bit e, input logic [7:0] pt, input bit ld, input bit sy);
    cfg_t       eff;
    int         nb, ki, a;
    logic [7:0] key, c, exp;
    eff = ld ? pin_cfg : shadow;
    nb  = (ld || sy) ? 0 : n_byte;
    ki  = (eff.rot_freq == 0) ? 0 : (nb / int'(eff.rot_freq)) % 3;
    key = (ki == 0) ? eff.k3 : (ki == 1) ? eff.k1 : eff.k2;
    a   = eff.shift_en ? int'(eff.shift_amt) : 0;
    c   = eff.mode ? (ref_perm(ref_rotl(pt, a)) ^ key) : pt;
    exp = pt;
    k1 = pin_cfg.k1; k2 = pin_cfg.k2; k3 = pin_cfg.k3;
    rot_freq = pin_cfg.rot_freq; shift_en = pin_cfg.shift_en;
    shift_amt = pin_cfg.shift_amt; mode = pin_cfg.mode;
    din = e ? c : 8'($urandom);
    en = e; cfg_ld = ld; sync = sy;
    @(posedge clk);
    #1;
    en = 0; cfg_ld = 0; sync = 0;
    if (ld) shadow = pin_cfg;
    n_byte = nb + (e ? 1 : 0);
    s2v = s1v;
    if (s1v) s2d = s1d;
    s1v = e;
    if (e) s1d = exp;
    check("v", {7'd0, v}, {7'd0, s2v});
    check("dout", dout, s2d);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_v", {7'd0, v}, 8'd0);
    check("rst_dout", dout, 8'd0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] order [256];
    pin_cfg = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_v", {7'd0, v}, 8'd0);
    check("reset_dout", dout, 8'd0);
    rst = 1'b1;

    // Bypass after reset: raw byte comes back two edges later.
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    check("byp_dout", dout, 8'hA5);
    check("byp_v", {7'd0, v}, 8'd1);
    step(0, 8'h00, 0, 0);

    // Single fixed key.
    pin_cfg = '0; pin_cfg.mode = 1; pin_cfg.k3 = 8'hFF;
    step(0, 8'h00, 1, 0);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 0, 0);
    check("single_key", dout, 8'h3C);
    step(0, 8'h00, 0, 0);

    // Key ring stepping every byte, zero plaintext.
    pin_cfg = '0; pin_cfg.mode = 1; pin_cfg.rot_freq = 3'd1;
    pin_cfg.k1 = 8'h11; pin_cfg.k2 = 8'h22; pin_cfg.k3 = 8'h33;
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 0);
    repeat (2) step(0, 8'h00, 0, 0);
    check("ring_last", dout, 8'h00);

    // Rotation period of 3, sync on byte 5.
    pin_cfg.rot_freq = 3'd3;
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, (i == 4));
    repeat (2) step(0, 8'h00, 0, 0);

    // Final rotate enabled.
    pin_cfg.shift_en = 1; pin_cfg.shift_amt = 3'd3;
    step(0, 8'h00, 1, 0);
    step(1, 8'h81, 0, 0);
    step(0, 8'h00, 0, 0);
    check("shift_dout", dout, 8'h81);
    step(0, 8'h00, 0, 0);

    // Randomised round trips over all byte values.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) order[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
        int j;
        logic [7:0] t;
        j = $urandom_range(i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      pin_cfg = rand_cfg();
      step(0, 8'h00, 1, 0);
      for (int i = 0; i < 256; i++) begin
        bit ld, sy;
        while ($urandom_range(3) == 0) step(0, 8'h00, 0, 0);
        ld = (i == 128);
        if (ld) pin_cfg = rand_cfg();
        sy = !ld && ($urandom_range(29) == 0);
        step(1, order[i], ld, sy);
        if (r == 1 && i == 200) begin
          pulse_reset();
          step(1, 8'($urandom), 0, 0);
          step(0, 8'h00, 1, 0);
        end
      end
      repeat (3) step(0, 8'h00, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
